// File: rtl/gray_arb_pkg.sv
// Shared constants and helpers for the round-robin binary-to-Gray conversion arbiter.
package gray_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 4;

  typedef enum logic {StEmpty, StFull} out_state_e;

  // Sized for the widest supported word; callers narrow the result with a cast.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  // Wraps at nreq, not at the next power of two.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at rr_ptr and wraps modulo NREQ.
module rr_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        idx = 32'(rr_ptr) + off;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = ID_W'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one binary-to-Gray stage among NREQ requesters; the result is registered with the
// source binary word and the winning requester ID.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  parameter  int unsigned W    = W_DEF,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_bin,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_gray,
  output logic [W-1:0]      out_bin,
  output logic [ID_W-1:0]   out_id
);

  out_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [W-1:0]    gray_q, gray_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            can_accept;
  logic            arb_enable;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic [W-1:0]    sel_bin;

  assign can_accept = (state_q == StEmpty) || out_ready;
  // Gating with rst_n keeps req_ready low for the whole time reset is asserted.
  assign arb_enable = can_accept && rst_n;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .enable    (arb_enable),
    .rr_ptr    (rr_ptr_q),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel_bin = req_bin[32'(grant_idx) * W +: W];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    bin_d    = bin_q;
    gray_d   = gray_q;
    id_d     = id_q;
    if (grant_any) begin
      state_d  = StFull;
      rr_ptr_d = ID_W'(rr_next(32'(grant_idx), NREQ));
      bin_d    = sel_bin;
      gray_d   = W'(bin2gray(16'(sel_bin)));
      id_d     = grant_idx;
    end else if (out_ready) begin
      // Drain with nothing to load: payload holds its last value.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      rr_ptr_q <= '0;
      bin_q    <= '0;
      gray_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_bin   = bin_q;
  assign out_gray  = gray_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter with NREQ=4, W=4.
module tb_gray_conv_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned ID_W = 2;

  localparam logic [3:0] GRAY_TBL [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };
  // Requester i carries bin 5+i in the fairness phase.
  localparam logic [3:0] RR_BIN  [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
  localparam logic [3:0] RR_GRAY [4] = '{4'b0111, 4'b0101, 4'b0100, 4'b1100};

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_gray;
  logic [W-1:0]      out_bin;
  logic [ID_W-1:0]   out_id;

  int n_cmp;
  int n_bad;

  gray_conv_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int i, input logic [W-1:0] v);
    req_bin[i*W +: W] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] b,
                           input logic [3:0] g, input logic [1:0] id);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".bin"},   32'(out_bin),   32'(b));
    check({tag, ".gray"},  32'(out_gray),  32'(g));
    check({tag, ".id"},    32'(out_id),    32'(id));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_bin   = '0;
    out_ready = 1'b1;

    // Reset: outputs zero, no ready even with requests present.
    tick();
    tick();
    check_out("reset", 1'b0, 4'h0, 4'h0, 2'd0);
    check("reset.ready", 32'(req_ready), 32'h0);

    // Single request from requester 0.
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    set_bin(0, 4'b0110);
    #1;
    check("single.ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check_out("single", 1'b1, 4'b0110, 4'b0101, 2'd0);

    // Back-to-back sweep from requester 2, no bubbles.
    for (int k = 0; k < 16; k++) begin
      req_valid = 4'b0100;
      set_bin(2, 4'(k));
      #1;
      check($sformatf("sweep%0d.ready", k), 32'(req_ready), 32'b0100);
      tick();
      check_out($sformatf("sweep%0d", k), 1'b1, 4'(k), GRAY_TBL[k], 2'd2);
    end

    // Drain to empty; payload holds.
    req_valid = 4'b0000;
    #1;
    check("drain.ready", 32'(req_ready), 32'h0);
    tick();
    check_out("drain", 1'b0, 4'b1111, 4'b1000, 2'd2);
    tick();
    check("idle.valid", 32'(out_valid), 32'h0);

    // rr_ptr stayed at 3 across idle cycles, so requester 3 wins among all four.
    for (int i = 0; i < 4; i++) set_bin(i, 4'd0);
    set_bin(3, 4'b1001);
    req_valid = 4'b1111;
    #1;
    check("after_idle.ready", 32'(req_ready), 32'b1000);
    tick();
    check_out("after_idle", 1'b1, 4'b1001, 4'b1101, 2'd3);

    // Round-robin fairness with all requesters active.
    for (int i = 0; i < 4; i++) set_bin(i, RR_BIN[i]);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check_out($sformatf("rr%0d", k), 1'b1, RR_BIN[k % 4], RR_GRAY[k % 4], 2'(k % 4));
    end

    // Backpressure: nothing accepted, outputs stable.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
      check_out($sformatf("bp%0d", k), 1'b1, 4'd8, 4'b1100, 2'd3);
      tick();
    end
    check_out("bp_end", 1'b1, 4'd8, 4'b1100, 2'd3);

    // Release: drain and accept in the same cycle.
    out_ready = 1'b1;
    #1;
    check("release.ready", 32'(req_ready), 32'b0001);
    tick();
    check_out("release", 1'b1, 4'd5, 4'b0111, 2'd0);
    #1;
    check("pre_rst.ready", 32'(req_ready), 32'b0010);
    tick();
    check_out("pre_rst", 1'b1, 4'd6, 4'b0101, 2'd1);

    // Asynchronous reset between edges with rr_ptr=2 and a pending result.
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 4'h0, 4'h0, 2'd0);
    check("async_rst.ready", 32'(req_ready), 32'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst.ready", 32'(req_ready), 32'b0001);
    tick();
    check_out("post_rst", 1'b1, 4'd5, 4'b0111, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
